// File: rtl/demux4_route_pkg.sv
// Shared encodings for the demux4_route Versat unit: FSM states and lane-select width.
package demux4_route_pkg;

  localparam int unsigned SEL_W     = 2;
  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDelay  = 2'd1,
    StActive = 2'd2
  } state_e;

endpackage

// File: rtl/demux4_route_if.sv
// Control, data and readback signals of the demux4_route unit.
interface demux4_route_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned DELAY_W = 16
);

  logic               running;
  logic               run;
  logic [DATA_W-1:0]  in0;
  logic [DATA_W-1:0]  in1;
  logic [DELAY_W-1:0] delay0;
  logic               holdMode;
  logic [DATA_W-1:0]  out0;
  logic [DATA_W-1:0]  out1;
  logic [DATA_W-1:0]  out2;
  logic [DATA_W-1:0]  out3;
  logic [COUNT_W-1:0] count0;
  logic [COUNT_W-1:0] count1;
  logic [COUNT_W-1:0] count2;
  logic [COUNT_W-1:0] count3;
  logic               done;

  modport master (
    output running, run, in0, in1, delay0, holdMode,
    input  out0, out1, out2, out3, count0, count1, count2, count3, done
  );

  modport slave (
    input  running, run, in0, in1, delay0, holdMode,
    output out0, out1, out2, out3, count0, count1, count2, count3, done
  );

endinterface

// File: rtl/demux4_route_lane.sv
// One output lane: registered data plus a saturating count of samples routed to it.
module demux4_route_lane #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic               zero,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  dout,
  output logic [COUNT_W-1:0] count
);

  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // clear (a run pulse) wins and leaves the data register untouched
  always_comb begin
    dout_d  = dout_q;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      dout_d = din;
      if (count_q != '1) begin
        count_d = count_q + COUNT_W'(1);
      end
    end else if (zero) begin
      dout_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q  <= '0;
      count_q <= '0;
    end else begin
      dout_q  <= dout_d;
      count_q <= count_d;
    end
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/demux4_route.sv
// Versat 1-to-4 demux: routes in0 to the lane chosen by in1[1:0], after an optional start delay.
module demux4_route
  import demux4_route_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned DELAY_W = 16
) (
  input logic           clk,
  input logic           rst,
  demux4_route_if.slave bus
);

  state_e               state_q, state_d;
  logic [DELAY_W-1:0]   dly_q, dly_d;
  logic [SEL_W-1:0]     sel;
  logic                 route;
  logic [NUM_LANES-1:0] lane_en;
  logic [NUM_LANES-1:0] lane_zero;
  logic [DATA_W-1:0]    lane_out [NUM_LANES];
  logic [COUNT_W-1:0]   lane_cnt [NUM_LANES];
  logic                 unused_in1;

  assign sel        = bus.in1[SEL_W-1:0];
  assign unused_in1 = ^bus.in1[DATA_W-1:SEL_W];

  // run restarts from any state; delay0 == N yields N cycles before the first routed sample
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    if (bus.run) begin
      dly_d   = bus.delay0;
      state_d = (bus.delay0 != '0) ? StDelay : StActive;
    end else begin
      unique case (state_q)
        StIdle: ;
        StDelay: begin
          if (bus.running) begin
            dly_d = dly_q - DELAY_W'(1);
            if (dly_q <= DELAY_W'(1)) begin
              state_d = StActive;
            end
          end
        end
        StActive: begin
          if (!bus.running) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  assign route    = (state_q == StActive) && bus.running && !bus.run;
  assign bus.done = (state_q == StIdle);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_en[i]   = route && (sel == SEL_W'(i));
    assign lane_zero[i] = route && (sel != SEL_W'(i)) && !bus.holdMode;

    demux4_route_lane #(
      .DATA_W  (DATA_W),
      .COUNT_W (COUNT_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.run),
      .en    (lane_en[i]),
      .zero  (lane_zero[i]),
      .din   (bus.in0),
      .dout  (lane_out[i]),
      .count (lane_cnt[i])
    );
  end

  assign bus.out0   = lane_out[0];
  assign bus.out1   = lane_out[1];
  assign bus.out2   = lane_out[2];
  assign bus.out3   = lane_out[3];
  assign bus.count0 = lane_cnt[0];
  assign bus.count1 = lane_cnt[1];
  assign bus.count2 = lane_cnt[2];
  assign bus.count3 = lane_cnt[3];

endmodule

// File: tb/tb_demux4_route.sv
// Bench for demux4_route: directed vector table, corner sequences and random traffic vs a model.
module tb_demux4_route;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 4;
  localparam int unsigned LW   = 16;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  demux4_route_if #(.DATA_W(DW), .COUNT_W(CW), .DELAY_W(LW)) bus ();

  demux4_route #(
    .DATA_W  (DW),
    .COUNT_W (CW),
    .DELAY_W (LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: lane contents, per-lane tallies, and how many idle cycles remain.
  logic [DW-1:0] m_out [4];
  int            m_cnt [4];
  bit            m_busy;
  bit            m_active;
  int            m_wait;

  typedef struct {
    logic [DW-1:0] din;
    logic [1:0]    sel;
    logic          hold;
    int            lane;
    logic [DW-1:0] exp_out;
    int            exp_cnt;
  } vec_t;

  vec_t vecs [7];

  logic [DW-1:0] exp_route [4] = '{32'h11, 32'h55, 32'h33, 32'h44};
  int            exp_rcnt  [4] = '{1, 2, 1, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] get_out(input int l);
    case (l)
      0:       return bus.out0;
      1:       return bus.out1;
      2:       return bus.out2;
      default: return bus.out3;
    endcase
  endfunction

  function automatic logic [CW-1:0] get_cnt(input int l);
    case (l)
      0:       return bus.count0;
      1:       return bus.count1;
      2:       return bus.count2;
      default: return bus.count3;
    endcase
  endfunction

  task automatic drive(input logic r, input logic rn, input logic [DW-1:0] d, input logic [1:0] s);
    bus.run     = r;
    bus.running = rn;
    bus.in0     = d;
    bus.in1     = ($urandom() & 32'hFFFF_FFFC) | {30'd0, s};
  endtask

  task automatic model_update();
    int s;
    s = int'(bus.in1[1:0]);
    if (!rst) begin
      for (int l = 0; l < 4; l++) begin
        m_out[l] = '0;
        m_cnt[l] = 0;
      end
      m_busy   = 1'b0;
      m_active = 1'b0;
      m_wait   = 0;
    end else if (bus.run) begin
      for (int l = 0; l < 4; l++) m_cnt[l] = 0;
      m_busy   = 1'b1;
      m_wait   = int'(bus.delay0);
      m_active = (m_wait == 0);
    end else if (m_busy && !m_active) begin
      if (bus.running) begin
        m_wait--;
        if (m_wait == 0) m_active = 1'b1;
      end
    end else if (m_active) begin
      if (bus.running) begin
        for (int l = 0; l < 4; l++) begin
          if (l == s) begin
            m_out[l] = bus.in0;
            m_cnt[l] = (m_cnt[l] < CMAX) ? m_cnt[l] + 1 : CMAX;
          end else if (!bus.holdMode) begin
            m_out[l] = '0;
          end
        end
      end else begin
        m_busy   = 1'b0;
        m_active = 1'b0;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".done"}, 64'(bus.done), 64'(!m_busy));
    for (int l = 0; l < 4; l++) begin
      check($sformatf("%s.out%0d", tag, l), 64'(get_out(l)), 64'(m_out[l]));
      check($sformatf("%s.count%0d", tag, l), 64'(get_cnt(l)), 64'(m_cnt[l]));
    end
  endtask

  task automatic apply_vec(input int i);
    bus.holdMode = vecs[i].hold;
    drive(1'b0, 1'b1, vecs[i].din, vecs[i].sel);
    step();
    check($sformatf("vec%0d.out", i), 64'(get_out(vecs[i].lane)), 64'(vecs[i].exp_out));
    check($sformatf("vec%0d.count", i), 64'(get_cnt(vecs[i].lane)), 64'(vecs[i].exp_cnt));
    compare_all($sformatf("vec%0d", i));
  endtask

  initial begin
    vecs[0] = '{32'h11, 2'd0, 1'b1, 0, 32'h11, 1};
    vecs[1] = '{32'h22, 2'd1, 1'b1, 1, 32'h22, 1};
    vecs[2] = '{32'h33, 2'd2, 1'b1, 2, 32'h33, 1};
    vecs[3] = '{32'h44, 2'd3, 1'b1, 3, 32'h44, 1};
    vecs[4] = '{32'h55, 2'd1, 1'b1, 1, 32'h55, 2};
    vecs[5] = '{32'h77, 2'd2, 1'b0, 2, 32'h77, 1};
    vecs[6] = '{32'h88, 2'd0, 1'b0, 2, 32'h00, 1};

    // Reset held two cycles while run is asserted
    rst          = 1'b0;
    bus.delay0   = '0;
    bus.holdMode = 1'b1;
    drive(1'b1, 1'b1, 32'hAA, 2'd0);
    step();
    step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 2'd0);
    check("reset.done", 64'(bus.done), 64'd1);
    check("reset.out1", 64'(bus.out1), 64'd0);
    compare_all("reset");

    // Routing with hold policy
    drive(1'b1, 1'b1, 32'h0, 2'd0);
    step();
    compare_all("run_route");
    for (int i = 0; i < 5; i++) apply_vec(i);
    for (int l = 0; l < 4; l++) begin
      check($sformatf("route.out%0d", l), 64'(get_out(l)), 64'(exp_route[l]));
      check($sformatf("route.count%0d", l), 64'(get_cnt(l)), 64'(exp_rcnt[l]));
    end

    // Zero policy in a fresh run
    drive(1'b0, 1'b0, 32'h0, 2'd0);
    step();
    bus.holdMode = 1'b0;
    drive(1'b1, 1'b1, 32'h0, 2'd0);
    step();
    for (int i = 5; i < 7; i++) apply_vec(i);
    check("zero.out0", 64'(bus.out0), 64'h88);

    // Start delay of three cycles
    drive(1'b0, 1'b0, 32'h0, 2'd0);
    step();
    compare_all("stop1");
    bus.holdMode = 1'b1;
    bus.delay0   = 16'd3;
    drive(1'b1, 1'b1, 32'h0, 2'd0);
    step();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 1'b1, DW'(k), 2'd0);
      step();
      compare_all($sformatf("delay%0d", k));
    end
    check("delay.out0", 64'(bus.out0), 64'h06);
    check("delay.count0", 64'(bus.count0), 64'd3);

    // Restart from ACTIVE; running low for two DELAY cycles stretches the wait
    drive(1'b1, 1'b1, 32'h0, 2'd0);
    step();
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, (k != 2 && k != 3), DW'(32'h10 + k), 2'd0);
      step();
      compare_all($sformatf("stretch%0d", k));
    end
    check("stretch.out0", 64'(bus.out0), 64'h17);
    check("stretch.count0", 64'(bus.count0), 64'd2);

    // Counter saturation on lane 3
    drive(1'b0, 1'b0, 32'h0, 2'd0);
    step();
    bus.delay0 = 16'd0;
    drive(1'b1, 1'b1, 32'h0, 2'd0);
    step();
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 1'b1, DW'(32'h300 + k), 2'd3);
      step();
      compare_all($sformatf("sat%0d", k));
    end
    check("sat.count3", 64'(bus.count3), 64'd15);
    check("sat.out3", 64'(bus.out3), 64'h314);

    // Restart mid-ACTIVE with a two-cycle delay
    bus.delay0 = 16'd2;
    drive(1'b1, 1'b1, 32'h0, 2'd0);
    step();
    check("restart.count3", 64'(bus.count3), 64'd0);
    check("restart.out3", 64'(bus.out3), 64'h314);
    check("restart.done", 64'(bus.done), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1, DW'(32'h400 + k), 2'd1);
      step();
      compare_all($sformatf("restart%0d", k));
    end
    check("restart.out1", 64'(bus.out1), 64'h404);
    check("restart.count1", 64'(bus.count1), 64'd2);

    // End of run: done rises, counts held
    drive(1'b0, 1'b0, 32'h0, 2'd0);
    step();
    check("end.done", 64'(bus.done), 64'd1);
    check("end.count1", 64'(bus.count1), 64'd2);

    // Reset in the middle of ACTIVE
    bus.delay0 = 16'd0;
    drive(1'b1, 1'b1, 32'h0, 2'd0);
    step();
    drive(1'b0, 1'b1, 32'h55, 2'd2);
    step();
    check("midrst.pre_out2", 64'(bus.out2), 64'h55);
    rst = 1'b0;
    drive(1'b1, 1'b1, 32'h66, 2'd2);
    step();
    rst = 1'b1;
    check("midrst.out2", 64'(bus.out2), 64'd0);
    check("midrst.done", 64'(bus.done), 64'd1);
    compare_all("midrst");

    // Random traffic; config only changes alongside a run pulse
    for (int c = 0; c < 400; c++) begin
      logic r;
      rst = ($urandom_range(0, 63) != 0);
      r   = ($urandom_range(0, 15) == 0);
      if (r) begin
        bus.holdMode = 1'($urandom_range(0, 1));
        bus.delay0   = 16'($urandom_range(0, 4));
      end
      drive(r, ($urandom_range(0, 7) != 0), DW'($urandom()), 2'($urandom_range(0, 3)));
      step();
      compare_all($sformatf("rand%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux4_route.md
Name: demux4_route

Overview:
- Versat functional unit; the inverse of the registered 4-way select unit.
- Steers one data stream (in0) to one of four registered outputs, chosen each cycle by a 2-bit selector (in1[1:0]).
- Adds a start delay after run, a hold/zero policy for non-selected lanes, and per-lane sample counters exposed as state.
- Sits in the Versat datapath wherever a producer feeds four consumers.

Parameters:
DATA_W, 32, width of in0 and out0..out3
COUNT_W, 16, width of each per-lane sample counter
DELAY_W, 16, width of delay0 config

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (rst==0 at posedge resets)
running  input  1  accelerator running window
run  input  1  one-cycle start pulse
in0  input  DATA_W  data to route
in1  input  DATA_W  selector; only [1:0] used, [DATA_W-1:2] ignored
delay0  input  DELAY_W  config: cycles to wait after run before routing
holdMode  input  1  config: 1 = non-selected lanes hold, 0 = non-selected lanes drive 0
out0..out3  output  DATA_W each  routed lane registers, versat_latency = 1
count0..count3  output  COUNT_W each  state: samples routed to each lane this run
done  output  1  state: 1 when unit is IDLE

Behaviour:
- Reset (rst==0 at posedge): out0..out3=0, count0..3=0, delay counter=0, state=IDLE, done=1. Reset overrides run and running in the same cycle.
- States: IDLE, DELAY, ACTIVE. done = (state==IDLE), registered.
- IDLE -> DELAY on run when delay0!=0; load delay counter = delay0.
- IDLE -> ACTIVE on run when delay0==0.
- Any run also clears count0..3 and leaves out* unchanged.
- run while DELAY or ACTIVE restarts the sequence: reload delay, clear counts, same transitions as from IDLE.
- run takes priority over every other condition except reset.
- DELAY, running==1: decrement counter each cycle. On the cycle the counter is 1, go to ACTIVE next. in0 is first routed on the cycle after the counter reaches 0 (delay0 = N gives N idle cycles).
- DELAY, running==0: freeze counter and state.
- ACTIVE, running==1, each cycle with sel=in1[1:0]:
  - out[sel] <= in0 (available 1 cycle later).
  - Non-selected lanes keep their value if holdMode==1, else load 0.
  - count[sel] += 1, saturating at 2^COUNT_W-1 (no wrap).
- ACTIVE, running==0: go to IDLE. Outputs and counts hold their values for readback.
- holdMode and delay0 are sampled live. Config must be stable during a run; the bench does not change them mid-run.
- Only one lane updates per cycle, so the four counters never increment together.

Decomposition:
- Shared package/header: state encoding localparams (IDLE=2'd0, DELAY=2'd1, ACTIVE=2'd2) and the lane-select width constant SEL_W=2.
- Sub-module demux4_route_lane, instantiated 4 times. Holds one output register and its saturating counter. Inputs: clk, rst, clear, en (lane selected & ACTIVE & running), zero (ACTIVE & running & !selected & !holdMode), din.
- Top level holds the FSM, the delay counter and the selector decode.

Test Plan:
- Reset: rst=0 for 2 cycles with run=1, in0=0xAA -> all out*=0, count*=0, done=1 after release.
- Routing, delay0=0, holdMode=1: pulse run, running=1, send (in0,sel) = (0x11,0),(0x22,1),(0x33,2),(0x44,3),(0x55,1) -> out0=0x11, out1=0x55, out2=0x33, out3=0x44, each one cycle after input; count0..3=1,2,1,1.
- Zero mode, holdMode=0: send (0x77,2) then (0x88,0) -> out2=0x77 for one cycle, then out2=0 and out0=0x88.
- Delay, delay0=3: run, then in0=0x01..0x06 all with sel=0 -> first three ignored, out0 sequence 0x04,0x05,0x06, count0=3. Dropping running for 2 cycles during DELAY extends the wait by 2.
- Saturation, COUNT_W=4: 20 samples to lane 3 -> count3=15, out3 is the last sample. A new run clears count3 to 0 and keeps out3.
- Restart, end and reset mid-run: run pulse during ACTIVE -> counts cleared, delay reloaded. running=0 -> done=1 next cycle, counts held. rst=0 mid-ACTIVE -> all zero, IDLE.
